ysyx_220066_bus_arbiter: RTL and testbench
==========================================

// Module: ysyx_220066_bus_arbiter
// PURPOSE
//  Shares one 64-bit memory bus between the instruction-fetch port and the load/store (M stage) port.
//  Fixed data-first priority with an anti-starvation guard for fetch; one outstanding transaction at a time.
//  Performs size/offset lane steering, write-mask generation, read sign/zero extension, alignment checks and a bus timeout.
// PARAMETERS
//  STARVE_LIMIT  4    max consecutive data grants while if_req is pending before fetch is forced
//  TIMEOUT       255  busy cycles without bus_ready before abort with error (8-bit counter)
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-low
//  if_req     in   1   fetch request; held until if_ready
//  if_addr    in   64  fetch address
//  if_flush   in   1   pipeline redirect; discard pending fetch response
//  if_ready   out  1   one-cycle fetch response pulse
//  if_rdata   out  32  instruction
//  if_err     out  1   fetch error, valid with if_ready
//  d_req      in   1   data request; held until d_ready
//  d_wen      in   1   1=store, 0=load
//  d_op       in   3   RV funct3: [1:0] size (B/H/W/D), [2]=unsigned load
//  d_addr     in   64  data address
//  d_wdata    in   64  store data, LSB-aligned
//  d_ready    out  1   one-cycle data response pulse
//  d_rdata    out  64  extended load data
//  d_err      out  1   data error, valid with d_ready
//  bus_valid  out  1   bus request
//  bus_wen    out  1   write enable
//  bus_addr   out  64  address, low 3 bits cleared
//  bus_wdata  out  64  lane-shifted write data
//  bus_wmask  out  8   byte mask
//  bus_ready  in   1   bus accept + complete (read data valid same cycle)
//  bus_rdata  in   64  read data
//  bus_err    in   1   bus error, valid with bus_ready
// BEHAVIOUR
//  - States: IDLE, IBUSY, DBUSY, IRESP, DRESP. All outputs registered; reset: state=IDLE, every output 0, counters 0.
//  - IDLE grant: d_req wins unless streak==STARVE_LIMIT and if_req; fetch granted only if if_req && !if_flush.
//  - Grant at cycle c0 latches request fields; bus_valid=1 from c1 and held stable until bus_ready.
//  - bus_ready high at ck -> bus_valid=0, rdata/err latched, state xRESP at ck+1 with x_ready pulse; IDLE at ck+2.
//  - Minimum latency request->ready: 2 cycles (bus_ready at c1). Requesters drop req the cycle after ready.
//  - Misaligned (fetch addr[1:0]!=0; data addr not multiple of 1<<size): no bus cycle, xRESP at c1 with err=1.
//  - wmask = ((1<<(1<<size))-1) << addr[2:0]; wdata = d_wdata << 8*addr[2:0]; loads bus_wmask=0.
//  - Load: shift bus_rdata right 8*addr[2:0], truncate to size, sign-extend if d_op[2]=0 else zero-extend; LD ignores [2].
//  - Fetch: if_rdata = addr[2] ? bus_rdata[63:32] : bus_rdata[31:0].
//  - streak: +1 per data grant while if_req pending, saturate at STARVE_LIMIT; cleared on fetch grant or !if_req in IDLE.
//  - Timeout: busy counter increments each BUSY cycle; reaching TIMEOUT -> bus_valid=0, xRESP with err=1; late bus_ready ignored.
//  - if_flush in IBUSY/IRESP: bus transaction completes, but if_ready stays 0 for it; flush never affects data port.
//  - bus_err propagates to x_err; rdata then 0.
//  - rst low mid-transaction: next edge IDLE, bus_valid=0, pending response dropped, no ready pulse.
// TESTING
//  1 Fetch 0x80000004, bus_ready at c1 with rdata 0x11223344_55667788 -> if_ready at c2, if_rdata=0x11223344, if_err=0.
//  2 Load LB @0x80000003, rdata byte3=0x80 -> d_rdata=0xFFFFFFFFFFFFFF80; LBU -> 0x80; SH @0x...6, wdata 0xBEEF -> wmask=0xC0, wdata[63:48]=0xBEEF.
//  3 if_req and d_req held continuously, bus_ready each c1 -> grant order D,D,D,D,I repeating (STARVE_LIMIT=4).
//  4 LW @0x80000002 -> no bus_valid, d_ready at c1, d_err=1; fetch @0x...2 -> if_err=1 likewise.
//  5 bus_ready never asserted -> bus_valid drops after 255 busy cycles, d_ready+d_err next cycle; later bus_ready ignored.
//  6 if_flush during IBUSY -> no if_ready; rst low during DBUSY -> bus_valid=0 next cycle, no d_ready, all outputs 0.

Source files
------------

// File: rtl/ysyx_220066_bus_arbiter.sv
// Shares one 64-bit memory bus between the instruction-fetch port and the
// load/store port. Data wins by default, but fetch is forced through after a
// run of STARVE_LIMIT data grants so it cannot be starved. Only one bus
// transaction is in flight at a time. The block also does lane steering for
// stores, sign/zero extension for loads, alignment checks and a bus timeout.
module ysyx_220066_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [2:0]  d_op,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        bus_valid,
    output logic        bus_wen,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wmask,
    input  logic        bus_ready,
    input  logic [63:0] bus_rdata,
    input  logic        bus_err
);

    localparam logic [7:0] STREAK_MAX = 8'(STARVE_LIMIT);
    localparam logic [7:0] BUSY_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IRESP, DRESP} state_t;

    state_t      state, state_nx;
    logic [7:0]  streak;
    logic [7:0]  busy_cnt;
    logic        flushed;
    logic [2:0]  lat_off;
    logic [2:0]  lat_op;
    logic        grant_i, grant_d;
    logic        mis_i, mis_d;
    logic        timeout;

    // An access of 1<<size bytes must sit on a multiple of its own size
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a[2:0];
        endcase
    endfunction

    // Byte-enable pattern for the access size, moved to its lane
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Bring the addressed lane down to bit 0, then sign- or zero-extend it
    function automatic logic [63:0] load_ext(input logic [63:0] rd, input logic [2:0] op,
                                             input logic [2:0] off);
        logic [63:0] sh;
        sh = rd >> {off, 3'b000};
        case (op[1:0])
            2'd0:    return op[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    return op[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    return op[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    assign mis_i   = |if_addr[1:0];
    assign mis_d   = misaligned(d_op[1:0], d_addr[2:0]);
    assign timeout = (busy_cnt == BUSY_LAST);

    // Arbitration and next-state selection
    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                grant_i = if_req && !if_flush && (!d_req || streak == STREAK_MAX);
                grant_d = d_req && !grant_i;
                if (grant_d)
                    state_nx = mis_d ? DRESP : DBUSY;
                else if (grant_i)
                    state_nx = mis_i ? IRESP : IBUSY;
            end
            IBUSY:   if (bus_ready || timeout) state_nx = IRESP;
            DBUSY:   if (bus_ready || timeout) state_nx = DRESP;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Registered bus outputs, responses, starvation streak and busy counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_ready  <= 1'b0;
            if_rdata  <= 32'd0;
            if_err    <= 1'b0;
            d_ready   <= 1'b0;
            d_rdata   <= 64'd0;
            d_err     <= 1'b0;
            bus_valid <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= 64'd0;
            bus_wdata <= 64'd0;
            bus_wmask <= 8'd0;
            streak    <= 8'd0;
            busy_cnt  <= 8'd0;
            flushed   <= 1'b0;
            lat_off   <= 3'd0;
            lat_op    <= 3'd0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    busy_cnt <= 8'd0;
                    flushed  <= 1'b0;
                    if (grant_d) begin
                        lat_off <= d_addr[2:0];
                        lat_op  <= d_op;
                        if (if_req)
                            streak <= (streak == STREAK_MAX) ? STREAK_MAX : streak + 8'd1;
                        else
                            streak <= 8'd0;
                        if (mis_d) begin
                            d_ready <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 64'd0;
                        end else begin
                            bus_valid <= 1'b1;
                            bus_wen   <= d_wen;
                            bus_addr  <= {d_addr[63:3], 3'b000};
                            bus_wdata <= d_wen ? (d_wdata << {d_addr[2:0], 3'b000}) : 64'd0;
                            bus_wmask <= d_wen ? lane_mask(d_op[1:0], d_addr[2:0]) : 8'd0;
                        end
                    end else if (grant_i) begin
                        streak  <= 8'd0;
                        lat_off <= if_addr[2:0];
                        if (mis_i) begin
                            if_ready <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= 32'd0;
                        end else begin
                            bus_valid <= 1'b1;
                            bus_wen   <= 1'b0;
                            bus_addr  <= {if_addr[63:3], 3'b000};
                            bus_wdata <= 64'd0;
                            bus_wmask <= 8'd0;
                        end
                    end else if (!if_req) begin
                        streak <= 8'd0;
                    end
                end
                IBUSY: begin
                    // A redirect seen at any point of the fetch suppresses its response
                    flushed <= flushed | if_flush;
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        if_ready  <= !(flushed || if_flush);
                        if_err    <= bus_err;
                        if_rdata  <= bus_err ? 32'd0 :
                                     (lat_off[2] ? bus_rdata[63:32] : bus_rdata[31:0]);
                    end else if (timeout) begin
                        bus_valid <= 1'b0;
                        if_ready  <= !(flushed || if_flush);
                        if_err    <= 1'b1;
                        if_rdata  <= 32'd0;
                    end else begin
                        busy_cnt <= busy_cnt + 8'd1;
                    end
                end
                DBUSY: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        d_ready   <= 1'b1;
                        d_err     <= bus_err;
                        d_rdata   <= bus_err ? 64'd0 : load_ext(bus_rdata, lat_op, lat_off);
                    end else if (timeout) begin
                        bus_valid <= 1'b0;
                        d_ready   <= 1'b1;
                        d_err     <= 1'b1;
                        d_rdata   <= 64'd0;
                    end else begin
                        busy_cnt <= busy_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_bus_arbiter.sv
// Directed bench for the fetch/data bus arbiter: a table of single
// transactions plus hand-written sequences for arbitration, timeout,
// flush and mid-transaction reset.
module tb_ysyx_220066_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush;
    logic [63:0] if_addr;
    logic        if_ready, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_wen;
    logic [2:0]  d_op;
    logic [63:0] d_addr, d_wdata;
    logic        d_ready, d_err;
    logic [63:0] d_rdata;
    logic        bus_valid, bus_wen;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_ready, bus_err;
    logic [63:0] bus_rdata;

    int tests  = 0;
    int failed = 0;

    ysyx_220066_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_wen(d_wen), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .bus_valid(bus_valid), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        wen;
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        berr;
        logic        exp_bus;
        logic [63:0] exp_baddr;
        logic [7:0]  exp_mask;
        logic [63:0] exp_bwdata;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_d, input logic wen, input logic [2:0] op,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input logic berr,
                                input logic exp_bus, input logic [63:0] exp_baddr,
                                input logic [7:0] exp_mask, input logic [63:0] exp_bwdata,
                                input logic [63:0] exp_rd, input logic exp_err);
        vec_t v;
        v.is_d = is_d; v.wen = wen; v.op = op; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.berr = berr; v.exp_bus = exp_bus; v.exp_baddr = exp_baddr;
        v.exp_mask = exp_mask; v.exp_bwdata = exp_bwdata; v.exp_rd = exp_rd;
        v.exp_err = exp_err;
        return v;
    endfunction

    // One transaction: request at a negedge, answer bus_valid immediately
    task automatic run_vec(input vec_t v, input int idx);
        logic rdy, done, seen_bus;
        int   lat;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_wen = v.wen; d_op = v.op; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        bus_rdata = v.rdata;
        bus_err   = v.berr;
        done = 1'b0; seen_bus = 1'b0; lat = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            lat++;
            bus_ready = 1'b0;
            rdy = v.is_d ? d_ready : if_ready;
            if (rdy) begin
                done = 1'b1;
                chk($sformatf("v%0d_latency", idx), 64'(lat), v.exp_bus ? 64'd2 : 64'd1);
                chk($sformatf("v%0d_bus_seen", idx), {63'd0, seen_bus}, {63'd0, v.exp_bus});
                if (v.is_d) begin
                    chk($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_rd);
                    chk($sformatf("v%0d_d_err", idx), {63'd0, d_err}, {63'd0, v.exp_err});
                end else begin
                    chk($sformatf("v%0d_if_rdata", idx), {32'd0, if_rdata}, v.exp_rd);
                    chk($sformatf("v%0d_if_err", idx), {63'd0, if_err}, {63'd0, v.exp_err});
                end
                d_req = 1'b0; if_req = 1'b0;
            end else if (bus_valid && !seen_bus) begin
                seen_bus = 1'b1;
                chk($sformatf("v%0d_bus_addr", idx), bus_addr, v.exp_baddr);
                chk($sformatf("v%0d_bus_wen", idx), {63'd0, bus_wen}, {63'd0, v.is_d & v.wen});
                chk($sformatf("v%0d_bus_wmask", idx), {56'd0, bus_wmask}, {56'd0, v.exp_mask});
                chk($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.exp_bwdata);
                bus_ready = 1'b1;
            end
        end
        if (!done) begin
            chk($sformatf("v%0d_ready_seen", idx), {63'd0, done}, 64'd1);
            d_req = 1'b0; if_req = 1'b0; bus_ready = 1'b0;
            repeat (300) @(negedge clk);
        end
    endtask

    logic order[10];
    int   n, vcnt;
    logic got;

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_wen = 1'b0; d_op = '0; d_addr = '0; d_wdata = '0;
        bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;

        //                 is_d wen op      addr                   wdata                  rdata                  berr bus baddr                 mask   bwdata                 exp_rd                 err
        vecs[0]  = mk(1'b0, 1'b0, 3'b000, 64'h80000004, 64'h0, 64'h1122334455667788, 1'b0, 1'b1, 64'h80000000, 8'h00, 64'h0, 64'h11223344, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 3'b000, 64'h80000000, 64'h0, 64'h1122334455667788, 1'b0, 1'b1, 64'h80000000, 8'h00, 64'h0, 64'h55667788, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 3'b000, 64'h80000003, 64'h0, 64'h0000000080000000, 1'b0, 1'b1, 64'h80000000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 3'b100, 64'h80000003, 64'h0, 64'h0000000080000000, 1'b0, 1'b1, 64'h80000000, 8'h00, 64'h0, 64'h80, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 3'b001, 64'h80000006, 64'hBEEF, 64'h0, 1'b0, 1'b1, 64'h80000000, 8'hC0, 64'hBEEF000000000000, 64'h0, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 3'b010, 64'h80000004, 64'h0, 64'h8765432100000000, 1'b0, 1'b1, 64'h80000000, 8'h00, 64'h0, 64'hFFFFFFFF87654321, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 3'b110, 64'h80000004, 64'h0, 64'h8765432100000000, 1'b0, 1'b1, 64'h80000000, 8'h00, 64'h0, 64'h0000000087654321, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 3'b011, 64'h80000008, 64'h0, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'h80000008, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 3'b001, 64'h80000002, 64'h0, 64'h000000007FFF0000, 1'b0, 1'b1, 64'h80000000, 8'h00, 64'h0, 64'h7FFF, 1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 3'b011, 64'h80000010, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0, 1'b1, 64'h80000010, 8'hFF, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 3'b000, 64'h80000001, 64'hAB, 64'h0, 1'b0, 1'b1, 64'h80000000, 8'h02, 64'hAB00, 64'h0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 3'b010, 64'h80000002, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 3'b000, 64'h80000002, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1);
        vecs[13] = mk(1'b1, 1'b0, 3'b000, 64'h80000000, 64'h0, 64'hFF, 1'b1, 1'b1, 64'h80000000, 8'h00, 64'h0, 64'h0, 1'b1);
        vecs[14] = mk(1'b1, 1'b1, 3'b010, 64'h8000000C, 64'h12345678, 64'h0, 1'b0, 1'b1, 64'h80000008, 8'hF0, 64'h1234567800000000, 64'h0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_valid", {63'd0, bus_valid}, 64'd0);
        chk("rst_if_ready", {63'd0, if_ready}, 64'd0);
        chk("rst_d_ready", {63'd0, d_ready}, 64'd0);
        chk("rst_bus_addr", bus_addr, 64'd0);
        chk("rst_bus_wmask", {56'd0, bus_wmask}, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        rst = 1'b1;

        // Single transactions
        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Both ports requesting continuously: four data grants, then fetch
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h1000;
        d_req = 1'b1; d_wen = 1'b0; d_op = 3'b011; d_addr = 64'h2000;
        bus_rdata = '0; bus_err = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(negedge clk);
            bus_ready = 1'b0;
            if (bus_valid) begin
                order[n] = (bus_addr == 64'h2000);
                n++;
                bus_ready = 1'b1;
            end
        end
        @(negedge clk);
        bus_ready = 1'b0; if_req = 1'b0; d_req = 1'b0;
        chk("arb_grant_count", 64'(n), 64'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("arb_grant%0d_is_data", i), {63'd0, order[i]}, {63'd0, (i % 5) != 4});
        repeat (3) @(negedge clk);

        // Bus never answers: abort after 255 busy cycles, late bus_ready ignored
        d_req = 1'b1; d_wen = 1'b0; d_op = 3'b011; d_addr = 64'h80000000;
        vcnt = 0; got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (d_ready) got = 1'b1;
            else if (bus_valid) vcnt++;
        end
        chk("to_ready_seen", {63'd0, got}, 64'd1);
        chk("to_valid_cycles", 64'(vcnt), 64'd255);
        chk("to_d_err", {63'd0, d_err}, 64'd1);
        chk("to_valid_dropped", {63'd0, bus_valid}, 64'd0);
        d_req = 1'b0;
        bus_ready = 1'b1;
        got = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (d_ready || bus_valid) got = 1'b1;
        end
        bus_ready = 1'b0;
        chk("to_late_ready_ignored", {63'd0, got}, 64'd0);

        // Flush during the fetch: bus completes, no if_ready
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h80000000; bus_rdata = 64'h1;
        @(negedge clk);
        chk("fl_bus_valid", {63'd0, bus_valid}, 64'd1);
        if_flush = 1'b1; bus_ready = 1'b1;
        @(negedge clk);
        if_flush = 1'b0; bus_ready = 1'b0; if_req = 1'b0;
        chk("fl_bus_done", {63'd0, bus_valid}, 64'd0);
        got = if_ready;
        repeat (4) begin
            @(negedge clk);
            if (if_ready) got = 1'b1;
        end
        chk("fl_no_if_ready", {63'd0, got}, 64'd0);

        // Reset asserted while a load is on the bus
        d_req = 1'b1; d_wen = 1'b0; d_op = 3'b011; d_addr = 64'h80000008;
        @(negedge clk);
        @(negedge clk);
        chk("mr_bus_valid_before", {63'd0, bus_valid}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_bus_valid", {63'd0, bus_valid}, 64'd0);
        chk("mr_bus_addr", bus_addr, 64'd0);
        chk("mr_d_ready", {63'd0, d_ready}, 64'd0);
        d_req = 1'b0; rst = 1'b1;
        got = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (d_ready || bus_valid) got = 1'b1;
        end
        chk("mr_no_response", {63'd0, got}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
